mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter that answers the CPU's data bus as a responder, alongside the RAM and the switch/LED decode. CPU stores to a data address enqueue bytes into a small FIFO. A shifter drains the FIFO onto a serial line as 8N1 frames, LSB first. The CPU polls a status register through the same bus with one-cycle registered read latency, matching RAM.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2
- TX_ADDR, 996, bus address of the TX data register (write-only)
- STAT_ADDR, 997, bus address of the status register (read; write clears overflow)
- FIFO_DEPTH, 4, TX FIFO entries; power of two, ≥ 2

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- addr  in  16  bus address, combinational from CPU, valid every cycle
- we  in  1  write strobe for the current cycle
- din  in  8  write data
- dout  out  8  registered read data
- sel  out  1  registered; 1 when the previous-cycle addr was TX_ADDR or STAT_ADDR, so the top-level read mux takes dout
- tx  out  1  serial line, idle high

## Operation
- Write decode: a cycle with we=1 and addr==TX_ADDR is a push of din.
  - The push is accepted if count<FIFO_DEPTH, or if the shifter pops in that same cycle.
  - Otherwise the byte is dropped and sticky ovf is set.
- Writing any value to STAT_ADDR clears ovf. If an overflow and a clear occur in the same cycle, the overflow wins and ovf=1.
- Status byte: bit0 full (count==FIFO_DEPTH), bit1 empty (count==0), bit2 busy (FSM≠IDLE), bit3 ovf, bits7:3... bits7:4 = 0.
- Reads have no side effects. Reading TX_ADDR returns 0x00.
- Read path, every cycle:
  - dout <= status if addr==STAT_ADDR, else 0x00.
  - sel <= (addr==TX_ADDR || addr==STAT_ADDR).
- FIFO: circular buffer with log2(FIFO_DEPTH)-bit read and write pointers that wrap modulo depth, plus a count of width log2(FIFO_DEPTH)+1. Simultaneous push and pop leave count unchanged.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop into shift register sh, load the baud counter, go to START. Otherwise stay; tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: tx=sh[0] for CLKS_PER_BIT cycles, then shift sh right and increment the index. After index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (zero gap). Otherwise go to IDLE.
- Baud counter: loads CLKS_PER_BIT-1, decrements each cycle, and the state advances when it reaches 0.
- tx is a registered output driven from the state and sh, so it is glitch-free.

## Timing
- Reset values (async assert, sync-safe release):
  - tx=1, dout=0x00, sel=0
  - FSM=IDLE, count=0, pointers=0, ovf=0
- Read latency: 1 cycle. addr presented in cycle N gives dout/sel valid in cycle N+1.
- Write to an empty FIFO with an IDLE FSM at edge E:
  - count=1 after E.
  - The pop occurs at E+1, and tx=0 from E+2.
- A frame lasts exactly 10×CLKS_PER_BIT cycles. Back-to-back frames have no idle cycles between stop and start.
- Status reflects state as of the edge that registers dout. A push at edge E is visible as empty=0 to a read whose address is presented in cycle E+1.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously), FIFO contents are discarded, and no partial frame resumes after release.
- Bus addresses other than TX_ADDR/STAT_ADDR never alter any state.

## Test plan
- Reset: hold rst_n=0, then release. Required: tx=1, sel=0, dout=0. Read STAT_ADDR returns 0x02 one cycle later.
- Single byte, CLKS_PER_BIT=4: write 0xA5 to 996.
  - tx=0 two cycles after the write edge.
  - Then bits 1,0,1,0,0,1,0,1, each 4 cycles.
  - Then stop bit high for 4 cycles; total 40 cycles.
  - Status during the frame is 0x06; afterwards 0x02.
- Back-to-back: write 0x01, 0x02, 0x03 on consecutive cycles. Required: three frames in 120 contiguous cycles, no idle gap, decoded in order 0x01, 0x02, 0x03.
- Overflow, FIFO_DEPTH=4:
  - Write 6 bytes on consecutive cycles; the first pops at once.
  - Required: the first 5 are accepted and sent, the 6th is dropped, and status bit3=1.
  - Write 0x00 to 997: bit3 clears.
- Full with simultaneous pop: fill the FIFO to 4 entries, then push in the exact cycle STOP ends. Required: the push is accepted, ovf stays 0, and all bytes are transmitted.
- Reset mid-frame: assert rst_n=0 during DATA bit 3. Required: tx=1 immediately. After release: status 0x02 and no further frames without new writes.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped UART transmitter that sits on the CPU data bus as a
// responder. Stores to TX_ADDR enqueue a byte into a small circular FIFO.
// A shifter drains the FIFO onto the serial line as 8N1 frames, LSB first.
// Reads of STAT_ADDR return the status byte. The read path has one cycle of
// registered latency, which matches the RAM.
//
// Status byte: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 sticky
// overflow, bits7:4 zero. Writing any value to STAT_ADDR clears overflow.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   addr   in  16   bus address, valid every cycle
//   we     in   1   write strobe for the current cycle
//   din    in   8   write data
//   dout   out  8   registered read data (status or 0x00)
//   sel    out  1   registered; previous-cycle addr hit TX_ADDR or STAT_ADDR
//   tx     out  1   serial line, idle high
// ---------------------------------------------------------------------------
module mmio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TX_ADDR      = 996,
  parameter int STAT_ADDR    = 997,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        sel,
  output logic        tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]       TX_A      = 16'(TX_ADDR);
  localparam logic [15:0]       STAT_A    = 16'(STAT_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Shifter state
  state_t              r_state;
  logic [BAUD_W-1:0]   r_baud;
  logic [2:0]          r_idx;
  logic [7:0]          r_sh;
  logic                r_tx;

  // FIFO state
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_ovf;

  // Read path
  logic [7:0]          r_dout;
  logic                r_sel;

  // Combinational
  logic                w_isTx;
  logic                w_isStat;
  logic                w_wrTx;
  logic                w_wrStat;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_ovfSet;
  logic [7:0]          w_status;
  logic [7:0]          w_head;
  state_t              w_stateNext;
  logic [BAUD_W-1:0]   w_baudNext;
  logic [2:0]          w_idxNext;
  logic [7:0]          w_shNext;
  logic                w_txNext;

  // -------------------------------------------------------------------------
  // Bus decode and status
  // -------------------------------------------------------------------------
  assign w_isTx   = (addr == TX_A);
  assign w_isStat = (addr == STAT_A);
  assign w_wrTx   = we && w_isTx;
  assign w_wrStat = we && w_isStat;

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_head   = r_mem[r_rptr];

  // A full FIFO still accepts a push when the shifter frees a slot in the
  // same cycle; the popped head is read before the write lands in its slot.
  assign w_push   = w_wrTx && (!w_full || w_pop);
  assign w_ovfSet = w_wrTx && !w_push;

  assign w_status = {4'b0000, r_ovf, (r_state != IDLE), w_empty, w_full};

  // -------------------------------------------------------------------------
  // Shifter next-state logic. Every state holds for CLKS_PER_BIT cycles via
  // the baud counter; STOP chains straight into START when data is waiting
  // so back-to-back frames have no idle gap.
  // -------------------------------------------------------------------------
  always_comb begin
    w_stateNext = r_state;
    w_baudNext  = r_baud;
    w_idxNext   = r_idx;
    w_shNext    = r_sh;
    w_pop       = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shNext    = w_head;
          w_baudNext  = BAUD_LOAD;
          w_stateNext = START;
        end
      end

      START: begin
        if (r_baud == '0) begin
          w_baudNext  = BAUD_LOAD;
          w_idxNext   = 3'd0;
          w_stateNext = DATA;
        end else begin
          w_baudNext  = r_baud - BAUD_W'(1);
        end
      end

      DATA: begin
        if (r_baud == '0) begin
          w_baudNext = BAUD_LOAD;
          w_shNext   = {1'b0, r_sh[7:1]};
          w_idxNext  = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_stateNext = STOP;
          end
        end else begin
          w_baudNext = r_baud - BAUD_W'(1);
        end
      end

      STOP: begin
        if (r_baud == '0) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shNext    = w_head;
            w_baudNext  = BAUD_LOAD;
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_baudNext = r_baud - BAUD_W'(1);
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // The serial line is a register fed from the current state and sh, so it
  // trails the state by one cycle but never glitches.
  always_comb begin
    w_txNext = 1'b1;
    case (r_state)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = r_sh[0];
      default: w_txNext = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Shifter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_idx   <= 3'd0;
      r_sh    <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_stateNext;
      r_baud  <= w_baudNext;
      r_idx   <= w_idxNext;
      r_sh    <= w_shNext;
      r_tx    <= w_txNext;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage. Contents need no reset: the pointers and count define
  // which entries are valid.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // FIFO pointers, occupancy and sticky overflow. An overflow in the same
  // cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovfSet) begin
        r_ovf <= 1'b1;
      end else if (w_wrStat) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered read path: one cycle latency, no read side effects.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= 8'h00;
      r_sel  <= 1'b0;
    end else begin
      r_dout <= w_isStat ? w_status : 8'h00;
      r_sel  <= w_isTx || w_isStat;
    end
  end

  assign dout = r_dout;
  assign sel  = r_sel;
  assign tx   = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_tx
//
// Directed and randomized bus traffic against mmio_uart_tx with a small
// reference model: a byte queue for the FIFO, a sticky overflow flag, and a
// frame timeline (pop edge + byte) from which the expected serial line is
// computed bit slot by bit slot.
// ---------------------------------------------------------------------------
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int TXA   = 996;
  localparam int STA   = 997;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        sel;
  logic        tx;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .TX_ADDR      (TXA),
    .STAT_ADDR    (STA),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .sel   (sel),
    .tx    (tx)
  );

  int cmpCount = 0;
  int errCount = 0;
  int edgeNum  = 0;

  // Reference model state
  logic [7:0] mQ[$];
  bit         mBusy;
  bit         mOvf;
  bit         mFrameValid;
  int         mCurP;
  logic [7:0] mCurByte;
  logic [7:0] expDout;
  logic       expSel;

  function automatic logic [7:0] modelStatus();
    return {4'b0000, mOvf, mBusy, (mQ.size() == 0), (mQ.size() == DEPTH)};
  endfunction

  // Frame popped at edge P drives the line from edge P+1 through P+10*CPB:
  // slot 0 start, slots 1..8 data LSB first, slot 9 stop.
  function automatic logic modelTx(int m);
    int slot;
    if (mFrameValid && m >= mCurP + 1 && m <= mCurP + 10 * CPB) begin
      slot = (m - mCurP - 1) / CPB;
      if (slot == 0) return 1'b0;
      if (slot == 9) return 1'b1;
      return mCurByte[slot-1];
    end
    return 1'b1;
  endfunction

  task automatic resetModel();
    mQ.delete();
    mBusy       = 1'b0;
    mOvf        = 1'b0;
    mFrameValid = 1'b0;
    mCurP       = 0;
    mCurByte    = 8'h00;
  endtask

  // Advance the model by one clock edge with the bus inputs of that cycle.
  task automatic modelEdge(input bit w, input logic [15:0] a, input logic [7:0] d);
    bit frameEnd;
    bit popNow;
    bit wrTx;
    bit accept;
    bit clr;
    frameEnd = mBusy && (edgeNum == mCurP + 10 * CPB);
    popNow   = (mQ.size() > 0) && (!mBusy || frameEnd);
    wrTx     = w && (a == 16'(TXA));
    clr      = w && (a == 16'(STA));
    accept   = (mQ.size() < DEPTH) || popNow;
    if (frameEnd && !popNow) mBusy = 1'b0;
    if (popNow) begin
      mCurByte    = mQ.pop_front();
      mCurP       = edgeNum;
      mFrameValid = 1'b1;
      mBusy       = 1'b1;
    end
    if (wrTx && accept) mQ.push_back(d);
    if (wrTx && !accept) mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
  endtask

  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    cmpCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edgeNum);
    end
  endtask

  task automatic checkOutput();
    checkValue("dout", dout, expDout);
    checkValue("sel", {7'b0, sel}, {7'b0, expSel});
    checkValue("tx", {7'b0, tx}, {7'b0, modelTx(edgeNum)});
  endtask

  // Drive one bus cycle, clock it, update the model and check all outputs.
  task automatic applyStimulus(input bit w, input logic [15:0] a, input logic [7:0] d);
    we      = w;
    addr    = a;
    din     = d;
    expDout = (a == 16'(STA)) ? modelStatus() : 8'h00;
    expSel  = (a == 16'(TXA)) || (a == 16'(STA));
    @(posedge clk);
    edgeNum++;
    modelEdge(w, a, d);
    #1;
    checkOutput();
  endtask

  task automatic pollStatus(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'(STA), 8'h00);
  endtask

  task automatic waitDrain(input int budget);
    int left;
    left = budget;
    while ((mBusy || mQ.size() > 0) && left > 0) begin
      applyStimulus(1'b0, 16'(STA), 8'h00);
      left--;
    end
    if (left == 0) begin
      cmpCount++;
      errCount++;
      $error("[TB] FAIL drain: observed timeout expected idle within %0d cycles", budget);
    end
    pollStatus(3);
  endtask

  initial begin
    int left;
    int r;
    logic [15:0] otherAddr;

    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 16'h0000;
    din   = 8'h00;
    resetModel();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkValue("rst_tx", {7'b0, tx}, 8'h01);
    checkValue("rst_sel", {7'b0, sel}, 8'h00);
    checkValue("rst_dout", dout, 8'h00);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'(STA), 8'h00);
    checkValue("rst_stat", dout, 8'h02);
    applyStimulus(1'b0, 16'(TXA), 8'h00);
    checkValue("read_tx_addr", dout, 8'h00);

    // Single byte 0xA5
    $display("[TB] single byte");
    applyStimulus(1'b1, 16'(TXA), 8'hA5);
    applyStimulus(1'b0, 16'(STA), 8'h00);
    checkValue("pre_start_tx", {7'b0, tx}, 8'h01);
    applyStimulus(1'b0, 16'(STA), 8'h00);
    checkValue("start_bit", {7'b0, tx}, 8'h00);
    checkValue("frame_stat", dout, 8'h06);
    pollStatus(45);
    checkValue("post_stat", dout, 8'h02);

    // Back-to-back
    $display("[TB] back-to-back");
    applyStimulus(1'b1, 16'(TXA), 8'h01);
    applyStimulus(1'b1, 16'(TXA), 8'h02);
    applyStimulus(1'b1, 16'(TXA), 8'h03);
    waitDrain(300);

    // Overflow: 6 writes, the 6th is dropped
    $display("[TB] overflow");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'(TXA), 8'($urandom));
    applyStimulus(1'b0, 16'(STA), 8'h00);
    checkValue("ovf_set", dout & 8'h08, 8'h08);
    applyStimulus(1'b1, 16'(STA), 8'h00);
    applyStimulus(1'b0, 16'(STA), 8'h00);
    checkValue("ovf_clr", dout & 8'h08, 8'h00);
    waitDrain(600);

    // Full FIFO with a push in the cycle STOP ends
    $display("[TB] full with simultaneous pop");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'(TXA), 8'($urandom));
    left = 200;
    while (edgeNum + 1 != mCurP + 10 * CPB && left > 0) begin
      applyStimulus(1'b0, 16'(STA), 8'h00);
      left--;
    end
    applyStimulus(1'b1, 16'(TXA), 8'h5A);
    applyStimulus(1'b0, 16'(STA), 8'h00);
    checkValue("simul_full_stat", dout & 8'h09, 8'h01);
    waitDrain(800);

    // Reset during DATA bit 3
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 16'(TXA), 8'h3C);
    left = 200;
    while (edgeNum != mCurP + 1 + 4 * CPB + 1 && left > 0) begin
      applyStimulus(1'b0, 16'(STA), 8'h00);
      left--;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("mid_rst_tx", {7'b0, tx}, 8'h01);
    checkValue("mid_rst_dout", dout, 8'h00);
    resetModel();
    we   = 1'b0;
    addr = 16'h0000;
    repeat (2) begin
      @(posedge clk);
      edgeNum++;
    end
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'(STA), 8'h00);
    checkValue("mid_rst_stat", dout, 8'h02);
    pollStatus(60);

    // Randomized bus traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) begin
        applyStimulus(1'b1, 16'(TXA), 8'($urandom));
      end else if (r < 30) begin
        applyStimulus(1'b1, 16'(STA), 8'($urandom));
      end else if (r < 60) begin
        applyStimulus(1'b0, 16'(STA), 8'h00);
      end else if (r < 75) begin
        otherAddr = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 995))
                                                : 16'($urandom_range(998, 65535));
        applyStimulus(1'($urandom), otherAddr, 8'($urandom));
      end else begin
        applyStimulus(1'b0, 16'(TXA), 8'h00);
      end
    end
    waitDrain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
